bit_stream_sync: RTL

BIT_STREAM_SYNC -- requirements
Module: bit_stream_sync

---
 rtl/bit_stream_sync.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/bit_stream_sync.sv
// Serial frame synchroniser: hunts for a sync word, verifies it recurs every FRAME_LEN bits, then tracks lock.
// Optional feature macro BIT_STREAM_SYNC_INV_EN: also acquire on the inverted sync word and report it on inv.
module bit_stream_sync #(
   parameter int PAT_W     = 8,
   parameter int FRAME_LEN = 32,
   parameter int LOCK_N    = 3,
   parameter int MISS_N    = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             din,
   input  logic [PAT_W-1:0] pattern,
   output logic             lock,
   output logic [1:0]       state,
   output logic             frame_start,
   output logic             inv
);

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2,
      BAD    = 2'd3
   } state_t;

   localparam int FILL_W = $clog2(PAT_W + 1);

   state_t            state_q;
   logic [PAT_W-1:0]  sr_q;
   logic [PAT_W-1:0]  win;
   logic [PAT_W-1:0]  ref_pat;
   logic [FILL_W-1:0] fill_q;
   logic [15:0]       pos_q;
   logic [3:0]        match_q;
   logic [3:0]        miss_q;
   logic              lock_q;
   logic              fs_q;
   logic              inv_q;
   logic              win_ok;
   logic              at_cp;
   logic              hit_pat;
   logic              hit_inv;
   logic              hunt_hit;
   logic              cp_hit;

   // Window includes the bit being accepted this edge, so a match is reported with no extra latency.
   assign win     = {sr_q[PAT_W-2:0], din};
   assign win_ok  = (fill_q >= FILL_W'(PAT_W - 1));
   assign at_cp   = (pos_q == 16'(FRAME_LEN - 1));
   assign hit_pat = win_ok && (win == pattern);
`ifdef BIT_STREAM_SYNC_INV_EN
   assign hit_inv = win_ok && (win == ~pattern) && !hit_pat;
`else
   assign hit_inv = 1'b0;
`endif
   assign hunt_hit = hit_pat || hit_inv;
   assign ref_pat  = inv_q ? ~pattern : pattern;
   assign cp_hit   = win_ok && (win == ref_pat);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= HUNT;
         sr_q    <= '0;
         fill_q  <= '0;
         pos_q   <= '0;
         match_q <= '0;
         miss_q  <= '0;
         lock_q  <= 1'b0;
         fs_q    <= 1'b0;
         inv_q   <= 1'b0;
      end else begin
         fs_q <= 1'b0;
         if (state_q == BAD) begin
            state_q <= HUNT;
            pos_q   <= '0;
            match_q <= '0;
            miss_q  <= '0;
            lock_q  <= 1'b0;
            inv_q   <= 1'b0;
         end else if (en) begin
            sr_q <= win;
            if (fill_q != FILL_W'(PAT_W)) fill_q <= fill_q + FILL_W'(1);
            case (state_q)
               HUNT: begin
                  if (hunt_hit) begin
                     pos_q   <= '0;
                     match_q <= 4'd1;
                     inv_q   <= hit_inv;
                     if (LOCK_N == 1) begin
                        state_q <= LOCKED;
                        lock_q  <= 1'b1;
                        fs_q    <= 1'b1;
                        miss_q  <= '0;
                     end else begin
                        state_q <= VERIFY;
                     end
                  end
               end
               VERIFY: begin
                  if (!at_cp) begin
                     pos_q <= pos_q + 16'd1;
                  end else if (cp_hit) begin
                     pos_q   <= '0;
                     match_q <= match_q + 4'd1;
                     if (match_q + 4'd1 == 4'(LOCK_N)) begin
                        state_q <= LOCKED;
                        lock_q  <= 1'b1;
                        fs_q    <= 1'b1;
                        miss_q  <= '0;
                     end
                  end else begin
                     // The failing checkpoint bit is deliberately not re-tried as a hunt match.
                     state_q <= HUNT;
                     pos_q   <= '0;
                     match_q <= '0;
                     miss_q  <= '0;
                     inv_q   <= 1'b0;
                  end
               end
               LOCKED: begin
                  if (!at_cp) begin
                     pos_q <= pos_q + 16'd1;
                  end else begin
                     pos_q <= '0;
                     if (cp_hit) begin
                        miss_q <= '0;
                        fs_q   <= 1'b1;
                     end else if (miss_q + 4'd1 == 4'(MISS_N)) begin
                        state_q <= HUNT;
                        lock_q  <= 1'b0;
                        match_q <= '0;
                        miss_q  <= '0;
                        inv_q   <= 1'b0;
                     end else begin
                        miss_q <= miss_q + 4'd1;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign state       = state_q;
   assign lock        = lock_q;
   assign frame_start = fs_q;
   assign inv         = inv_q;

endmodule
